// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit: tag and operands travel through LATENCY-1 register
// stages, compute is combinational in the last stage, and results land in registered outputs.
// Optional multiplier for opcode 13 is enabled by defining FU_ALU_MUL_EN.
module fu_alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int ID_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             flush,
    input  logic [3:0]       ALUControl,
    input  logic [ID_W-1:0]  FU_ID,
    input  logic [WIDTH-1:0] ALUA,
    input  logic [WIDTH-1:0] ALUB,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow,
    output logic [ID_W-1:0]  finish,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_AP4  = 4'd11;
    localparam logic [3:0] OP_BOUT = 4'd12;
`ifdef FU_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd13;
`endif

    // Issue protocol: there is no ready; an op is accepted on every rising edge with EN=1
    // and always completes LATENCY cycles later unless a flush or reset kills it first.
    logic             l_valid;
    logic [ID_W-1:0]  l_tag;
    logic [3:0]       l_op;
    logic [WIDTH-1:0] l_a;
    logic [WIDTH-1:0] l_b;

    generate
        if (LATENCY == 1) begin : g_direct
            assign l_valid = EN;
            assign l_tag   = FU_ID;
            assign l_op    = ALUControl;
            assign l_a     = ALUA;
            assign l_b     = ALUB;
            assign busy    = 1'b0;
        end else begin : g_pipe
            logic [LATENCY-1:1] p_valid;
            logic [ID_W-1:0]    p_tag [1:LATENCY-1];
            logic [3:0]         p_op  [1:LATENCY-1];
            logic [WIDTH-1:0]   p_a   [1:LATENCY-1];
            logic [WIDTH-1:0]   p_b   [1:LATENCY-1];

            // A newly issued op is never killed by a flush on its own issue edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p_valid <= '0;
                    for (int k = 1; k < LATENCY; k++) begin
                        p_tag[k] <= '0;
                        p_op[k]  <= '0;
                        p_a[k]   <= '0;
                        p_b[k]   <= '0;
                    end
                end else begin
                    p_valid[1] <= EN;
                    p_tag[1]   <= FU_ID;
                    p_op[1]    <= ALUControl;
                    p_a[1]     <= ALUA;
                    p_b[1]     <= ALUB;
                    for (int k = 2; k < LATENCY; k++) begin
                        p_valid[k] <= p_valid[k-1] && !flush;
                        p_tag[k]   <= p_tag[k-1];
                        p_op[k]    <= p_op[k-1];
                        p_a[k]     <= p_a[k-1];
                        p_b[k]     <= p_b[k-1];
                    end
                end
            end

            assign l_valid = p_valid[LATENCY-1] && !flush;
            assign l_tag   = p_tag[LATENCY-1];
            assign l_op    = p_op[LATENCY-1];
            assign l_a     = p_a[LATENCY-1];
            assign l_b     = p_b[LATENCY-1];
            assign busy    = |p_valid;
        end
    endgenerate

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] r_comb;
    logic             o_comb;

    always_comb begin
        sum    = l_a + l_b;
        diff   = l_a - l_b;
        shamt  = l_b[SH_W-1:0];
        r_comb = '0;
        o_comb = 1'b0;
        case (l_op)
            OP_ADD: begin
                r_comb = sum;
                o_comb = (l_a[WIDTH-1] == l_b[WIDTH-1]) && (sum[WIDTH-1] != l_a[WIDTH-1]);
            end
            OP_SUB: begin
                r_comb = diff;
                o_comb = (l_a[WIDTH-1] != l_b[WIDTH-1]) && (diff[WIDTH-1] != l_a[WIDTH-1]);
            end
            OP_AND:  r_comb = l_a & l_b;
            OP_OR:   r_comb = l_a | l_b;
            OP_XOR:  r_comb = l_a ^ l_b;
            OP_SLL:  r_comb = l_a << shamt;
            OP_SRL:  r_comb = l_a >> shamt;
            OP_SLT:  r_comb = {{(WIDTH-1){1'b0}}, ($signed(l_a) < $signed(l_b))};
            OP_SLTU: r_comb = {{(WIDTH-1){1'b0}}, (l_a < l_b)};
            OP_SRA:  r_comb = $signed(l_a) >>> shamt;
            OP_AP4:  r_comb = l_a + {{(WIDTH-3){1'b0}}, 3'd4};
            OP_BOUT: r_comb = l_b;
`ifdef FU_ALU_MUL_EN
            OP_MUL:  r_comb = l_a * l_b;
`endif
            default: r_comb = '0;
        endcase
    end

    // Result outputs load only on a surviving completion and otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res      <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            finish   <= '0;
        end else begin
            finish <= l_valid ? l_tag : '0;
            if (l_valid) begin
                res      <= r_comb;
                zero     <= (r_comb == '0);
                overflow <= o_comb;
            end
        end
    end

endmodule

// File: doc/fu_alu_pipe.md
# fu_alu_pipe

Parametrised, fully pipelined integer ALU functional unit for the scoreboard/issue back-end. It accepts one operation per cycle, carries the issuing unit's FU tag through a configurable-depth pipeline, and returns the result with a one-cycle `finish` tag pulse exactly `LATENCY` cycles after issue. A synchronous flush discards in-flight operations.

## Interface
- `WIDTH`, 32: operand and result width; must be a power of two, minimum 8.
- `LATENCY`, 2: cycles from the issue edge to the result being visible; legal range 1..4.
- `ID_W`, 4: FU tag width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `EN` input 1: issue strobe; operands are captured on the rising edge where `EN`=1.
- `flush` input 1: synchronous kill of all in-flight operations.
- `ALUControl` input 4: operation code.
- `FU_ID` input ID_W: tag returned on completion; must be nonzero.
- `ALUA`, `ALUB` input WIDTH: operands.
- `res` output WIDTH: result of the last completed operation.
- `zero` output 1: `res` == 0.
- `overflow` output 1: signed overflow of the last completed ADD/SUB.
- `finish` output ID_W: tag of the operation completing this cycle; 0 otherwise.
- `busy` output 1: at least one operation is in flight (captured, not yet completed).

## Operation
- Opcodes:
  - ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SLT=8, SLTU=9, SRA=10.
  - Ap4=11 (A+4), Bout=12 (B), MUL=13 (Configuration only).
- Shift amount is `ALUB[log2(WIDTH)-1:0]`. Upper bits are ignored.
- Arithmetic is modulo 2^WIDTH.
  - SLT is signed; SLTU is unsigned. Both return 0 or 1, zero-extended.
  - SRA replicates the sign bit.
- `overflow` is set only for ADD (pos+pos=neg, neg+neg=pos) or SUB (pos−neg=neg, neg−pos=pos). It is 0 for every other op.
- Undefined opcode: `res`=0, `zero`=1, `overflow`=0. It completes normally with its tag.
- Pipeline: valid bit, tag, opcode and operands shift one stage per cycle, unconditionally (no back-pressure).
- Compute is combinational in the last stage. `res`, `zero` and `overflow` are registered outputs, loaded only on completion.
- Between completions, `res`, `zero` and `overflow` hold their last completed value.
- `finish` is nonzero for exactly one cycle per completed operation.
- Flush:
  - `flush`=1 clears every valid bit in flight, including one completing that cycle.
  - `finish` is 0 on the following cycle.
  - `res`, `zero` and `overflow` are not updated by killed operations.
- `EN` and `flush` in the same cycle: in-flight ops are killed, and the newly issued op is accepted and completes normally.

## Timing
- Issue at edge N (`EN`=1) → `finish`=`FU_ID`, with `res`, `zero` and `overflow` valid, in the cycle following edge N+LATENCY−1.
  - LATENCY=1: the result is visible in the cycle right after the issue edge.
- Throughput is 1 op/cycle. Back-to-back issues complete on consecutive cycles, in order.
- `busy` = OR of all in-flight valid bits, taken from registers (no combinational path from `EN`).
- Reset (`rst`=0, asynchronous): all valid bits 0, `res`=0, `zero`=1, `overflow`=0, `finish`=0, `busy`=0.
- Reset asserted mid-operation drops all in-flight ops immediately. No `finish` is ever produced for them.
- Release of `rst` is synchronous to `clk`. The first issue is accepted on the first edge after release.

## Configuration
- `FU_ALU_MUL_EN` defined: opcode 13 computes the low WIDTH bits of `ALUA*ALUB` (sign-agnostic), with the same latency as the other ops. `overflow`=0.
- `FU_ALU_MUL_EN` undefined: no multiplier is instantiated. Opcode 13 behaves as an undefined opcode.

## Test plan
- Reset, then WIDTH=32, LATENCY=2: issue ADD 0x7FFFFFFF+1, tag 3 → two edges later `finish`=3, `res`=0x80000000, `overflow`=1, `zero`=0. The next cycle `finish`=0 and `res` holds.
- Back-to-back issues over 3 cycles:
  - Ops: SUB 5−5 tag 1; SLT 0xFFFFFFFF,1 tag 2; SRA 0x80000000>>31 tag 4.
  - Completions on consecutive cycles: `res`=0 with `zero`=1; `res`=1; `res`=0xFFFFFFFF. Tags 1, 2, 4 in order.
- Issue SLTU 1,0xFFFFFFFF tag 5; assert `flush` the next cycle → no `finish`, `res` unchanged, `busy`=0 after the flush edge.
- `flush` and `EN` (SLL 1<<36, tag 6) in the same cycle with one op in flight → only tag 6 completes, with `res`=0x10 (shamt=4).
- Assert `rst` with 2 ops in flight → immediately `finish`=0, `busy`=0, `res`=0, `zero`=1. No completions after release.
- Opcode 13 with 6×7, tag 7 → `res`=42 with `FU_ALU_MUL_EN` defined, `res`=0 without. `finish`=7 in both builds.
